// File: rtl/ikaopll_smpl_out_if.sv
// Sample stream between the output stage and the board-level audio serializer.
// The master presents a signed sample with valid and the slave accepts it with ready.
interface ikaopll_smpl_out_if;
  logic               valid;
  logic signed [15:0] data;
  logic               ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ikaopll_smpl_out.sv
// Sample output stage.
// - Captures one mixed sample per frame from the accumulation DAC.
// - Applies an optional first-order DC-blocking high-pass to that sample.
// - Queues the result in a small FIFO and presents it on a valid/ready stream.
// The FIFO lets a stalling consumer coexist with the chip-timed sample rate.
module ikaopll_smpl_out #(
  parameter int FIFO_DEPTH = 4,
  parameter int DCB_SHIFT  = 8
) (
  input  logic                          emuclk,
  input  logic                          rst_n,
  input  logic                          phi1_ncen_n,
  input  logic                          acc_signed_strb,
  input  logic signed [15:0]            acc_signed,
  input  logic                          dcb_en,
  ikaopll_smpl_out_if.master            smpl,
  output logic [7:0]                    ovf_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILT = 2'd1;
  localparam logic [1:0] ST_PUSH = 2'd2;

  localparam logic signed [18:0] S16_MAX = 19'sd32767;
  localparam logic signed [18:0] S16_MIN = -19'sd32768;
  localparam logic signed [18:0] S18_MAX = 19'sd131071;
  localparam logic signed [18:0] S18_MIN = -19'sd131072;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if ((DCB_SHIFT < 4) || (DCB_SHIFT > 12)) begin : g_bad_shift
    $error("DCB_SHIFT must be in 4..12");
  end

  // Clamp the wide filter result to the 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    logic signed [18:0] c;
    if (v > S16_MAX)      c = S16_MAX;
    else if (v < S16_MIN) c = S16_MIN;
    else                  c = v;
    return c[15:0];
  endfunction

  // Clamp the wide filter result to the 18-bit feedback state range.
  function automatic logic signed [17:0] clamp18(input logic signed [18:0] v);
    logic signed [18:0] c;
    if (v > S18_MAX)      c = S18_MAX;
    else if (v < S18_MIN) c = S18_MIN;
    else                  c = v;
    return c[17:0];
  endfunction

  logic [1:0]            state;
  logic                  strb_z;
  logic                  capture;
  logic signed [15:0]    x_p0;
  logic signed [15:0]    xprev;
  logic signed [17:0]    yprev;
  logic signed [16:0]    d_p0;
  logic signed [17:0]    leak_p0;
  logic signed [18:0]    yn_p0;
  logic signed [15:0]    res_p1;

  logic signed [15:0]    mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [LVL_W-1:0]      lvl;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push_req;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  // Strobe delay line; starts high so a strobe held across reset release is not taken as an edge.
  always_ff @(posedge emuclk or negedge rst_n) begin
    if (!rst_n)            strb_z <= 1'b1;
    else if (!phi1_ncen_n) strb_z <= acc_signed_strb;
  end

  // Edges arriving during a busy FSM are ignored; the frame period makes that unreachable.
  assign capture = ~phi1_ncen_n & acc_signed_strb & ~strb_z & (state == ST_IDLE);

  // Sequencer: capture -> filter -> push, one step per emuclk independent of the enable.
  always_ff @(posedge emuclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (capture) state <= ST_FILT;
        ST_FILT: state <= ST_PUSH;
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0: sample capture ----
  // Hold the captured sample for the filter step.
  always_ff @(posedge emuclk) begin
    if (capture) x_p0 <= acc_signed;
  end

  // y[n] = y[n-1] + (x[n] - x[n-1]) - (y[n-1] >>> k), evaluated wide enough not to wrap.
  always_comb begin
    d_p0    = 17'(x_p0) - 17'(xprev);
    leak_p0 = yprev >>> DCB_SHIFT;
    yn_p0   = 19'(yprev) + 19'(d_p0) - 19'(leak_p0);
  end

  // Filter state advances even in bypass so re-enabling the blocker starts from fresh history.
  always_ff @(posedge emuclk or negedge rst_n) begin
    if (!rst_n) begin
      xprev <= '0;
      yprev <= '0;
    end else if (state == ST_FILT) begin
      xprev <= x_p0;
      yprev <= clamp18(yn_p0);
    end
  end

  // ---- stage p1: filtered or raw result ----
  // Select the blocker output or the untouched sample for queueing.
  always_ff @(posedge emuclk) begin
    if (state == ST_FILT) res_p1 <= dcb_en ? sat16(yn_p0) : x_p0;
  end

  // ---- stage p2: FIFO ----
  assign lvl        = wr_ptr - rd_ptr;
  assign fifo_empty = (lvl == '0);
  assign fifo_full  = (lvl == LVL_W'(FIFO_DEPTH));
  assign push_req   = (state == ST_PUSH);
  assign pop        = smpl.valid & smpl.ready;
  // When full, a same-cycle pop frees the slot being written (wr and rd address coincide).
  assign wr_en      = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;

  // Sample storage; contents are only meaningful between the pointers.
  always_ff @(posedge emuclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= res_p1;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge emuclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Count samples lost to a full FIFO, sticking at the top.
  always_ff @(posedge emuclk or negedge rst_n) begin
    if (!rst_n)                       ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  assign smpl.valid = ~fifo_empty;
  assign smpl.data  = fifo_empty ? 16'sd0 : mem[rd_ptr[AW-1:0]];
  assign fifo_lvl   = lvl;

endmodule

// File: tb/tb_ikaopll_smpl_out.sv
// Directed bench for the sample output stage with a queue-based scoreboard.
module tb_ikaopll_smpl_out;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               phi;
  logic               strb;
  logic signed [15:0] acc;
  logic               dcb_en;
  logic [7:0]         ovf;
  logic [2:0]         lvl;

  always #5 clk = ~clk;

  ikaopll_smpl_out_if sif();

  ikaopll_smpl_out #(.FIFO_DEPTH(4), .DCB_SHIFT(8)) dut (
    .emuclk          (clk),
    .rst_n           (rst_n),
    .phi1_ncen_n     (phi),
    .acc_signed_strb (strb),
    .acc_signed      (acc),
    .dcb_en          (dcb_en),
    .smpl            (sif),
    .ovf_cnt         (ovf),
    .fifo_lvl        (lvl)
  );

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One strobe pulse carrying v; returns one ns after the capturing edge.
  task automatic frame(input int v);
    repeat (18) @(posedge clk);
    #1;
    acc  = 16'(v);
    strb = 1'b1;
    @(posedge clk);
    #1;
    strb = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every accepted handshake is compared against the scoreboard head.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (rst_n && sif.valid && sif.ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'(sif.data), 99999);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", int'(sif.data), e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    phi       = 1'b0;
    strb      = 1'b0;
    acc       = '0;
    dcb_en    = 1'b0;
    sif.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(sif.valid), 0);
    chk("rst_data",  int'(sif.data),  0);
    chk("rst_lvl",   int'(lvl),       0);
    chk("rst_ovf",   int'(ovf),       0);
    rst_n = 1'b1;

    // Bypass with latency and single-cycle valid pulse
    sif.ready = 1'b1;
    exp_q.push_back(1234);
    frame(1234);
    @(negedge clk); chk("lat_filt_valid",  int'(sif.valid), 0);
    @(negedge clk); chk("lat_push_valid",  int'(sif.valid), 0);
    @(negedge clk); chk("lat_out_valid",   int'(sif.valid), 1);
    @(negedge clk); chk("pulse_end_valid", int'(sif.valid), 0);
    exp_q.push_back(-5);
    frame(-5);
    repeat (4) @(posedge clk);

    // DC blocker step response
    do_reset();
    dcb_en = 1'b1;
    exp_q.push_back(1000); frame(1000);
    exp_q.push_back(997);  frame(1000);
    exp_q.push_back(994);  frame(1000);
    exp_q.push_back(-9);   frame(0);
    repeat (4) @(posedge clk);

    // Saturation; the third frame exposes the unclamped-to-16b feedback value -32895
    do_reset();
    exp_q.push_back(32767);  frame(32767);
    exp_q.push_back(-32768); frame(-32768);
    exp_q.push_back(-32766); frame(-32768);
    repeat (4) @(posedge clk);

    // Backpressure and overflow
    do_reset();
    dcb_en    = 1'b0;
    sif.ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) exp_q.push_back(i);
      frame(i);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("ovf_lvl",        int'(lvl),       4);
    chk("ovf_cnt",        int'(ovf),       2);
    chk("hold_valid",     int'(sif.valid), 1);
    chk("hold_data",      int'(sif.data),  1);
    sif.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_lvl", int'(lvl), 0);
    sif.ready = 1'b0;

    // Full FIFO with a pop in the push cycle
    for (int i = 11; i <= 14; i++) begin
      exp_q.push_back(i);
      frame(i);
    end
    exp_q.push_back(15);
    frame(15);
    @(posedge clk);
    #1 sif.ready = 1'b1;
    @(posedge clk);
    #1 sif.ready = 1'b0;
    chk("fullpop_lvl",  int'(lvl),      4);
    chk("fullpop_ovf",  int'(ovf),      2);
    chk("fullpop_head", int'(sif.data), 12);
    sif.ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("fullpop_drain_lvl", int'(lvl), 0);
    sif.ready = 1'b0;

    // Asynchronous reset during the filter step with two entries queued
    exp_q.push_back(21); frame(21);
    exp_q.push_back(22); frame(22);
    frame(23);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(sif.valid), 0);
    chk("arst_data",  int'(sif.data),  0);
    chk("arst_lvl",   int'(lvl),       0);
    chk("arst_ovf",   int'(ovf),       0);
    exp_q.delete();
    strb = 1'b1;
    acc  = 16'sd999;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("strb_high_release_lvl", int'(lvl), 0);
    strb      = 1'b0;
    dcb_en    = 1'b1;
    sif.ready = 1'b1;
    exp_q.push_back(700);
    frame(700);
    repeat (6) @(posedge clk);
    #1;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
